// File: rtl/pll_pkg.sv
// Shared types, default sizes and arithmetic helpers for the OCXO PI loop filter.
package pll_pkg;

  localparam int DAC_W_DEF  = 20;
  localparam int ERR_W_DEF  = 24;
  localparam int GAIN_W_DEF = 16;
  localparam int ACC_W_DEF  = 48;
  localparam int FRAC_W_DEF = 16;

  // One-hot sequencing of the single shared multiplier and adder
  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_CAP   = 7'b000_0010,
    ST_MUL_I = 7'b000_0100,
    ST_ACC   = 7'b000_1000,
    ST_MUL_P = 7'b001_0000,
    ST_SUM   = 7'b010_0000,
    ST_OUT   = 7'b100_0000
  } pll_state_t;

  // Signed add of two accumulator-width values, saturated to the accumulator range
  function automatic logic signed [ACC_W_DEF-1:0] sat_add(
    input  logic signed [ACC_W_DEF-1:0] a,
    input  logic signed [ACC_W_DEF-1:0] b,
    output logic                        clip
  );
    logic [ACC_W_DEF:0] s;
    s    = {a[ACC_W_DEF-1], a} + {b[ACC_W_DEF-1], b};
    clip = (s[ACC_W_DEF] != s[ACC_W_DEF-1]);
    if (!clip)
      return s[ACC_W_DEF-1:0];
    else if (s[ACC_W_DEF])
      return {1'b1, {(ACC_W_DEF-1){1'b0}}};
    else
      return {1'b0, {(ACC_W_DEF-1){1'b1}}};
  endfunction

endpackage

// File: rtl/pll_sat.sv
// Signed saturating resize from IN_W to OUT_W bits with a clip indication.
// UNSIGNED_OUT limits to [0, 2**OUT_W-1]; SYMMETRIC uses -(max) as the lower bound.
module pll_sat #(
  parameter int IN_W         = 49,
  parameter int OUT_W        = 48,
  parameter bit UNSIGNED_OUT = 1'b0,
  parameter bit SYMMETRIC    = 1'b0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] ONE   = 1;
  localparam logic signed [IN_W-1:0] MAX_V = UNSIGNED_OUT ? ((ONE <<< OUT_W) - ONE)
                                                          : ((ONE <<< (OUT_W-1)) - ONE);
  localparam logic signed [IN_W-1:0] MIN_V = UNSIGNED_OUT ? {IN_W{1'b0}}
                                           : (SYMMETRIC ? -MAX_V : -(ONE <<< (OUT_W-1)));

  // Compare against the bounds in the wide domain and pick the bound or the truncated value
  always_comb begin
    clip = 1'b0;
    dout = din[OUT_W-1:0];
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      clip = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/pll_loop_filter.sv
// PI loop filter disciplining the OCXO DAC from the TSC phase/frequency detector.
// One shared signed multiplier and one saturating adder are stepped by a short FSM:
// integral term is folded into the accumulator, proportional term only into the output.
module pll_loop_filter
  import pll_pkg::*;
#(
  parameter int DAC_W  = DAC_W_DEF,
  parameter int ERR_W  = ERR_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pll_trig,
  input  logic                     pfd_status,
  input  logic signed [31:0]       pdiff_1pps,
  input  logic signed [31:0]       fdiff_1pps,
  input  logic                     loop_en,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic                     load_init,
  input  logic        [DAC_W-1:0]  dac_init,
  output logic        [DAC_W-1:0]  dac_val,
  output logic                     dac_upd,
  output logic                     busy,
  output logic        [2:0]        sat_flags,
  output logic                     overrun
);

  localparam int PROD_W = ERR_W + GAIN_W;
  localparam int HEAD_W = ACC_W - DAC_W - FRAC_W;
  localparam logic signed [ACC_W-1:0] ACC_RST = {{HEAD_W{1'b0}}, DAC_MID, {FRAC_W{1'b0}}};

  pll_state_t state_q, state_d;

  logic signed [ERR_W-1:0]  pe_q, fe_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q, sum_q;
  logic                     out_clip_q, acc_sat_q, err_clamp_q;

  logic                     trig_ok;
  logic signed [GAIN_W-1:0] mul_gain;
  logic signed [ERR_W-1:0]  mul_err;
  logic signed [PROD_W-1:0] mul_res;
  logic        [ACC_W:0]    add_wide;
  logic signed [ACC_W-1:0]  sum_shift;
  logic signed [ACC_W-1:0]  acc_preset;

  logic [ERR_W-1:0] pe_clamp, fe_clamp;
  logic             pe_clip, fe_clip;
  logic [ACC_W-1:0] add_sat;
  logic             add_clip;
  logic [DAC_W-1:0] out_sat;
  logic             out_clip;

  assign trig_ok    = pll_trig & loop_en & ~pfd_status;
  assign busy       = (state_q != ST_IDLE);
  assign sat_flags  = {out_clip_q, acc_sat_q, err_clamp_q};
  assign acc_preset = {{HEAD_W{1'b0}}, dac_init, {FRAC_W{1'b0}}};
  assign sum_shift  = sum_q >>> FRAC_W;

  // Error inputs are limited to a symmetric range so the multiplier never sees -2**(ERR_W-1)
  pll_sat #(.IN_W(32), .OUT_W(ERR_W), .UNSIGNED_OUT(1'b0), .SYMMETRIC(1'b1)) u_pe_clamp (
    .din  (pdiff_1pps),
    .dout (pe_clamp),
    .clip (pe_clip)
  );

  pll_sat #(.IN_W(32), .OUT_W(ERR_W), .UNSIGNED_OUT(1'b0), .SYMMETRIC(1'b1)) u_fe_clamp (
    .din  (fdiff_1pps),
    .dout (fe_clamp),
    .clip (fe_clip)
  );

  // One adder serves both the integrator update and the output sum
  pll_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .UNSIGNED_OUT(1'b0), .SYMMETRIC(1'b0)) u_acc_sat (
    .din  ($signed(add_wide)),
    .dout (add_sat),
    .clip (add_clip)
  );

  // Integer part of the sum is clipped onto the unsigned DAC code range
  pll_sat #(.IN_W(ACC_W), .OUT_W(DAC_W), .UNSIGNED_OUT(1'b1), .SYMMETRIC(1'b0)) u_out_clip (
    .din  (sum_shift),
    .dout (out_sat),
    .clip (out_clip)
  );

  // Shared multiplier operand selection; product truncated to PROD_W is exact for signed operands
  always_comb begin
    mul_gain = ki;
    mul_err  = pe_q;
    if (state_q == ST_MUL_P) begin
      mul_gain = kp;
      mul_err  = fe_q;
    end
    mul_res  = $signed({{ERR_W{mul_gain[GAIN_W-1]}}, mul_gain}
                     * {{GAIN_W{mul_err[ERR_W-1]}}, mul_err});
    add_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: a fixed one-cycle-per-step walk, with load_init aborting from anywhere
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = trig_ok ? ST_CAP : ST_IDLE;
      ST_CAP:   state_d = ST_MUL_I;
      ST_MUL_I: state_d = ST_ACC;
      ST_ACC:   state_d = ST_MUL_P;
      ST_MUL_P: state_d = ST_SUM;
      ST_SUM:   state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (load_init)
      state_d = ST_IDLE;
  end

  // Datapath registers, sticky flags and outputs; load_init overrides every step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_q        <= '0;
      fe_q        <= '0;
      prod_q      <= '0;
      acc_q       <= ACC_RST;
      sum_q       <= '0;
      dac_val     <= DAC_MID;
      dac_upd     <= 1'b0;
      out_clip_q  <= 1'b0;
      acc_sat_q   <= 1'b0;
      err_clamp_q <= 1'b0;
      overrun     <= 1'b0;
    end else if (load_init) begin
      acc_q       <= acc_preset;
      dac_val     <= dac_init;
      dac_upd     <= 1'b1;
      out_clip_q  <= 1'b0;
      acc_sat_q   <= 1'b0;
      err_clamp_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      dac_upd <= 1'b0;
      if (pll_trig && (state_q != ST_IDLE))
        overrun <= 1'b1;
      case (state_q)
        ST_CAP: begin
          pe_q <= $signed(pe_clamp);
          fe_q <= $signed(fe_clamp);
          if (pe_clip || fe_clip)
            err_clamp_q <= 1'b1;
        end
        ST_MUL_I, ST_MUL_P: begin
          prod_q <= mul_res;
        end
        ST_ACC: begin
          acc_q <= $signed(add_sat);
          if (add_clip)
            acc_sat_q <= 1'b1;
        end
        ST_SUM: begin
          sum_q <= $signed(add_sat);
          if (add_clip)
            acc_sat_q <= 1'b1;
        end
        ST_OUT: begin
          dac_val <= out_sat;
          dac_upd <= 1'b1;
          if (out_clip)
            out_clip_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed self-checking bench for pll_loop_filter with hand-computed DAC codes.
module tb_pll_loop_filter;

  logic               clk;
  logic               rst;
  logic               pll_trig;
  logic               pfd_status;
  logic signed [31:0] pdiff_1pps;
  logic signed [31:0] fdiff_1pps;
  logic               loop_en;
  logic signed [15:0] kp;
  logic signed [15:0] ki;
  logic               load_init;
  logic        [19:0] dac_init;
  logic        [19:0] dac_val;
  logic               dac_upd;
  logic               busy;
  logic        [2:0]  sat_flags;
  logic               overrun;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int   lat;
  int   upd_cnt;
  logic saw_busy;

  pll_loop_filter dut (
    .clk        (clk),
    .rst        (rst),
    .pll_trig   (pll_trig),
    .pfd_status (pfd_status),
    .pdiff_1pps (pdiff_1pps),
    .fdiff_1pps (fdiff_1pps),
    .loop_en    (loop_en),
    .kp         (kp),
    .ki         (ki),
    .load_init  (load_init),
    .dac_init   (dac_init),
    .dac_val    (dac_val),
    .dac_upd    (dac_upd),
    .busy       (busy),
    .sat_flags  (sat_flags),
    .overrun    (overrun)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Count dac_upd pulses over a number of cycles, sampling 1 ns after each edge
  task automatic countUpd(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (dac_upd) cnt++;
    end
  endtask

  // Present a measurement, pulse pll_trig, and watch a bounded window for dac_upd
  task automatic applyStimulus(input logic signed [31:0] pd, input logic signed [31:0] fd,
                               output int latency, output int ucnt, output logic sbusy);
    pdiff_1pps = pd;
    fdiff_1pps = fd;
    @(posedge clk);
    #1 pll_trig = 1'b1;
    @(posedge clk);
    #1 pll_trig = 1'b0;
    latency = 0;
    ucnt    = 0;
    sbusy   = busy;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (dac_upd) begin
        ucnt++;
        if (latency == 0) latency = n;
      end
      sbusy = sbusy | busy;
    end
  endtask

  // One-cycle load_init pulse
  task automatic loadInit(input logic [19:0] v);
    @(posedge clk);
    #1 load_init = 1'b1;
    dac_init = v;
    @(posedge clk);
    #1 load_init = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pll_trig   = 1'b0;
    pfd_status = 1'b0;
    pdiff_1pps = '0;
    fdiff_1pps = '0;
    loop_en    = 1'b1;
    kp         = '0;
    ki         = '0;
    load_init  = 1'b0;
    dac_init   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_dac_val", 32'(dac_val), 32'h80000);
    checkOutput("rst_dac_upd", 32'(dac_upd), 32'd0);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    checkOutput("rst_flags",   32'(sat_flags), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    // Integral path: each trigger adds 0x100*256 = 1.0 LSB to the integrator
    ki = 16'sh0100;
    kp = 16'sh0000;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(32'sd256, 32'sd0, lat, upd_cnt, saw_busy);
      checkOutput($sformatf("int_dac_%0d", i), 32'(dac_val), 32'h80000 + 32'(i));
      checkOutput($sformatf("int_lat_%0d", i), 32'(lat), 32'd6);
      checkOutput($sformatf("int_upd_%0d", i), 32'(upd_cnt), 32'd1);
      repeat (5) @(posedge clk);
    end
    checkOutput("int_busy_seen", 32'(saw_busy), 32'd1);

    // Proportional path has no memory
    loadInit(20'h80000);
    checkOutput("load_mid", 32'(dac_val), 32'h80000);
    ki = 16'sh0000;
    kp = 16'sh0200;
    applyStimulus(32'sd0, 32'sd128, lat, upd_cnt, saw_busy);
    checkOutput("prop_dac_1", 32'(dac_val), 32'h80001);
    applyStimulus(32'sd0, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("prop_dac_2", 32'(dac_val), 32'h80000);

    // Gated triggers
    ki = 16'sh0100;
    loop_en = 1'b0;
    applyStimulus(32'sd256, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("noloop_upd",  32'(upd_cnt),  32'd0);
    checkOutput("noloop_busy", 32'(saw_busy), 32'd0);
    checkOutput("noloop_dac",  32'(dac_val),  32'h80000);
    loop_en = 1'b1;
    pfd_status = 1'b1;
    applyStimulus(32'sd256, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("pfd_upd",  32'(upd_cnt),  32'd0);
    checkOutput("pfd_busy", 32'(saw_busy), 32'd0);
    checkOutput("pfd_dac",  32'(dac_val),  32'h80000);
    pfd_status = 1'b0;

    // Error clamp and output clip at the top of the range
    ki = 16'sh7FFF;
    kp = 16'sh0000;
    applyStimulus(32'sh7FFFFFFF, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("clip_dac_1", 32'(dac_val), 32'hFFFFF);
    applyStimulus(32'sh7FFFFFFF, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("clip_dac_2", 32'(dac_val), 32'hFFFFF);
    checkOutput("clip_flags", 32'(sat_flags), 32'b101);

    // Overrun: second trigger three cycles after the first
    loadInit(20'h80000);
    checkOutput("load_flags_clr", 32'(sat_flags), 32'd0);
    ki = 16'sh0100;
    pdiff_1pps = 32'sd256;
    fdiff_1pps = 32'sd0;
    @(posedge clk);
    #1 pll_trig = 1'b1;
    @(posedge clk);
    #1 pll_trig = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 pll_trig = 1'b1;
    @(posedge clk);
    #1 pll_trig = 1'b0;
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    countUpd(12, upd_cnt);
    checkOutput("ovr_upd_cnt", 32'(upd_cnt), 32'd1);
    checkOutput("ovr_dac", 32'(dac_val), 32'h80001);

    // load_init aborts a running computation
    @(posedge clk);
    #1 pll_trig = 1'b1;
    @(posedge clk);
    #1 pll_trig = 1'b0;
    @(posedge clk);
    #1 load_init = 1'b1;
    dac_init = 20'h12345;
    @(posedge clk);
    #1 load_init = 1'b0;
    checkOutput("abort_dac",   32'(dac_val),   32'h12345);
    checkOutput("abort_upd",   32'(dac_upd),   32'd1);
    checkOutput("abort_busy",  32'(busy),      32'd0);
    checkOutput("abort_flags", 32'(sat_flags), 32'd0);
    checkOutput("abort_ovr",   32'(overrun),   32'd0);
    countUpd(10, upd_cnt);
    checkOutput("abort_no_upd", 32'(upd_cnt), 32'd0);
    checkOutput("abort_hold",   32'(dac_val), 32'h12345);

    // load_init and pll_trig together: trigger dropped
    @(posedge clk);
    #1 load_init = 1'b1;
    pll_trig = 1'b1;
    @(posedge clk);
    #1 load_init = 1'b0;
    pll_trig = 1'b0;
    checkOutput("both_busy", 32'(busy),    32'd0);
    checkOutput("both_ovr",  32'(overrun), 32'd0);
    countUpd(10, upd_cnt);
    checkOutput("both_no_upd", 32'(upd_cnt), 32'd0);

    // Integrator continues from the preset, both signs
    applyStimulus(32'sd256, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("preset_up", 32'(dac_val), 32'h12346);
    applyStimulus(-32'sd512, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("preset_dn", 32'(dac_val), 32'h12344);

    // Lower output clip at zero
    loadInit(20'h00000);
    applyStimulus(-32'sd256, 32'sd0, lat, upd_cnt, saw_busy);
    checkOutput("floor_dac",   32'(dac_val),   32'h00000);
    checkOutput("floor_lat",   32'(lat),       32'd6);
    checkOutput("floor_flags", 32'(sat_flags), 32'b100);

    // Asynchronous reset during a computation
    @(posedge clk);
    #1 pll_trig = 1'b1;
    @(posedge clk);
    #1 pll_trig = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_dac",   32'(dac_val),   32'h80000);
    checkOutput("mid_rst_busy",  32'(busy),      32'd0);
    checkOutput("mid_rst_flags", 32'(sat_flags), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    countUpd(10, upd_cnt);
    checkOutput("mid_rst_no_upd", 32'(upd_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
